adam_periph_spi_fifo: RTL and testbench
=======================================

ADAM_PERIPH_SPI_FIFO -- requirements
Module: adam_periph_spi_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of every data word.
REQ-002 SHALL have parameter DEPTH, default 8, entries per FIFO; power of two, >= 2.
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports pause_req input 1 / pause_ack output 1  host pause handshake.
REQ-006 SHALL have ports phy_pause_req output 1 / phy_pause_ack input 1  pause handshake toward the SPI PHY.
REQ-007 SHALL have port flush  input  1  single-cycle pulse; empties both FIFOs.
REQ-008 SHALL have ports tx_data input DATA_WIDTH, tx_valid input 1, tx_ready output 1  host write stream.
REQ-009 SHALL have ports rx_data output DATA_WIDTH, rx_valid output 1, rx_ready input 1  host read stream.
REQ-010 SHALL have ports phy_tx output DATA_WIDTH, phy_tx_valid output 1, phy_tx_ready input 1  stream into the PHY.
REQ-011 SHALL have ports phy_rx input DATA_WIDTH, phy_rx_valid input 1, phy_rx_ready output 1  stream from the PHY.
REQ-012 SHALL have ports tx_level, rx_level  output  $clog2(DEPTH)+1  current occupancy.
REQ-013 SHALL have port rx_overflow  output  1  sticky; set when an RX word is dropped.

Function
REQ-014 Transfer rule: a word moves only in a cycle where valid && ready is sampled high; valid, once raised, SHALL hold with stable data until accepted.
REQ-015 TX FIFO: tx_ready = !tx_full && state==RUN; phy_tx/phy_tx_valid present head (first-word-fall-through); write-to-phy_tx_valid latency 1 cycle.
REQ-016 RX FIFO: phy_rx_ready SHALL be constant 1 (PHY never stalls); word accepted while full SHALL be dropped and set rx_overflow; rx_valid = !rx_empty; latency 1 cycle.
REQ-017 Simultaneous push and pop on one FIFO: level unchanged; when full, pop frees slot next cycle only (no same-cycle pass-through on TX); on RX a push while full and popping SHALL be stored, not dropped.
REQ-018 Pointers SHALL wrap modulo DEPTH with one extra wrap bit; level = wr_ptr - rd_ptr in $clog2(DEPTH)+1 bits.
REQ-019 State machine: RUN -> PAUSING on pause_req; PAUSING: phy_tx_valid held until any in-flight offered word is accepted, then phy_pause_req=1; -> PAUSED when phy_pause_ack=1; PAUSED: pause_ack=1; -> RESUMING on !pause_req, phy_pause_req=0; -> RUN when phy_pause_ack=0 (pause_ack=0 there).
REQ-020 phy_tx_valid SHALL be 0 in PAUSED and RESUMING; not newly asserted in PAUSING.
REQ-021 flush SHALL act only in PAUSED: both FIFOs emptied, rx_overflow cleared, next cycle levels 0; flush in other states ignored.
REQ-022 RX acceptance continues in all states (PHY may complete a frame while pausing).

Reset
REQ-023 On rst=0: state RUN, pointers 0, levels 0, rx_overflow 0, tx_ready 0 until first clk after release, all valid/ack/req outputs 0, data outputs 0.
REQ-024 Reset mid-transfer SHALL discard all stored words; no partial word is ever output.

Configuration
REQ-025 Macro ADAM_PERIPH_SPI_FIFO_IRQ_EN: when defined, adds inputs tx_thresh, rx_thresh ($clog2(DEPTH)+1) and output irq, registered, =1 when tx_level <= tx_thresh or rx_level >= rx_thresh (rx_thresh 0 disables RX term) or rx_overflow; when undefined, these ports and logic are absent.

Structure
REQ-026 Shared package adam_periph_spi_pkg SHALL hold the state enum (RUN, PAUSING, PAUSED, RESUMING) and level type helper.
REQ-027 One sub-module adam_periph_spi_fifo_q (parameterised FWFT queue with flush, level, full/empty) SHALL be instantiated twice.

Verification
REQ-028 Write 0xAA..0xB3 (10 words, DEPTH 8) with phy_tx_ready=0 -> 8 accepted, tx_ready=0, tx_level=8; release -> phy_tx order 0xAA..0xB3.
REQ-029 Push 9 RX words 0x00..0x08 with rx_ready=0 -> rx_level=8, rx_overflow=1, reads return 0x00..0x07.
REQ-030 pause_req while phy_tx_valid=1 and phy_tx_ready=0 -> phy_tx_valid held until accept, then phy_pause_req=1; phy_pause_ack=1 -> pause_ack=1 next cycle.
REQ-031 flush pulse in PAUSED with tx_level=3, rx_level=2 -> both 0, rx_overflow 0 next cycle; flush in RUN -> no change.
REQ-032 rst=0 asynchronously with tx_level=5 -> all outputs 0 immediately; after release tx_level=0 and no phy_tx_valid.
REQ-033 With ADAM_PERIPH_SPI_FIFO_IRQ_EN, rx_thresh=4: fourth RX word -> irq=1 next cycle; one read -> irq=0.

Source files
------------

// File: rtl/adam_periph_spi_pkg.sv
// Shared types for the SPI FIFO peripheral: controller state encoding and
// the occupancy-width helper used by the queue and the top.
package adam_periph_spi_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    PAUSING  = 2'd1,
    PAUSED   = 2'd2,
    RESUMING = 2'd3
  } spi_state_e;

  // Occupancy counters need one bit beyond the address so "full" is representable.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/adam_periph_spi_fifo_q.sv
// First-word-fall-through queue with synchronous flush, occupancy and
// full/empty flags. A push while full is only stored when a pop frees a slot.
module adam_periph_spi_fifo_q
  import adam_periph_spi_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  localparam int LW        = level_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic [LW-1:0]         level,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]           wr_ptr_reg;
  logic [AW:0]           rd_ptr_reg;
  logic                  do_pop;
  logic                  do_push;

  // Pointers carry one wrap bit: equal low bits with differing wrap bits means full.
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign level   = wr_ptr_reg - rd_ptr_reg;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Storage carries no reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end

  assign head = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/adam_periph_spi_fifo.sv
// SPI PHY buffering: TX/RX FWFT queues plus a pause handshake controller.
// Optional threshold interrupt built when ADAM_PERIPH_SPI_FIFO_IRQ_EN is defined.
module adam_periph_spi_fifo
  import adam_periph_spi_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  localparam int LW        = level_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pause_req,
  output logic                  pause_ack,
  output logic                  phy_pause_req,
  input  logic                  phy_pause_ack,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic [DATA_WIDTH-1:0] phy_tx,
  output logic                  phy_tx_valid,
  input  logic                  phy_tx_ready,
  input  logic [DATA_WIDTH-1:0] phy_rx,
  input  logic                  phy_rx_valid,
  output logic                  phy_rx_ready,
  output logic [LW-1:0]         tx_level,
  output logic [LW-1:0]         rx_level,
  output logic                  rx_overflow
`ifdef ADAM_PERIPH_SPI_FIFO_IRQ_EN
  ,
  input  logic [LW-1:0]         tx_thresh,
  input  logic [LW-1:0]         rx_thresh,
  output logic                  irq
`endif
);

  spi_state_e state_reg;
  spi_state_e state_next;
  logic       rst_done_reg;
  logic       offered_reg;
  logic       rx_overflow_reg;
  logic       flush_act;
  logic       tx_full;
  logic       tx_empty;
  logic       rx_full;
  logic       rx_empty;
  logic       rx_drop;

  assign flush_act    = flush && (state_reg == PAUSED);
  assign phy_rx_ready = 1'b1;
  assign rx_valid     = !rx_empty;
  // Reader not draining a full queue this cycle means the incoming word is lost.
  assign rx_drop      = phy_rx_valid && rx_full && !rx_ready;
  assign rx_overflow  = rx_overflow_reg;

  adam_periph_spi_fifo_q #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_tx_q (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush_act),
    .push      (tx_valid && tx_ready),
    .push_data (tx_data),
    .pop       (phy_tx_valid && phy_tx_ready),
    .head      (phy_tx),
    .level     (tx_level),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  adam_periph_spi_fifo_q #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_rx_q (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush_act),
    .push      (phy_rx_valid),
    .push_data (phy_rx),
    .pop       (rx_ready),
    .head      (rx_data),
    .level     (rx_level),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= RUN;
      rst_done_reg    <= 1'b0;
      offered_reg     <= 1'b0;
      rx_overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rst_done_reg <= 1'b1;
      // Remembers a PHY offer left pending so PAUSING keeps presenting it.
      offered_reg  <= phy_tx_valid && !phy_tx_ready;
      if (flush_act)    rx_overflow_reg <= 1'b0;
      else if (rx_drop) rx_overflow_reg <= 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:      if (pause_req)                     state_next = PAUSING;
      PAUSING:  if (!offered_reg && phy_pause_ack) state_next = PAUSED;
      PAUSED:   if (!pause_req)                    state_next = RESUMING;
      RESUMING: if (!phy_pause_ack)                state_next = RUN;
      default:                                     state_next = RUN;
    endcase
  end

  always_comb begin
    tx_ready      = 1'b0;
    phy_tx_valid  = 1'b0;
    phy_pause_req = 1'b0;
    pause_ack     = 1'b0;
    case (state_reg)
      RUN: begin
        tx_ready     = rst_done_reg && !tx_full;
        phy_tx_valid = !tx_empty;
      end
      PAUSING: begin
        phy_tx_valid  = offered_reg;
        phy_pause_req = !offered_reg;
      end
      PAUSED: begin
        phy_pause_req = 1'b1;
        pause_ack     = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef ADAM_PERIPH_SPI_FIFO_IRQ_EN
  logic irq_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_reg <= 1'b0;
    end else begin
      irq_reg <= (tx_level <= tx_thresh) ||
                 ((rx_thresh != '0) && (rx_level >= rx_thresh)) ||
                 rx_overflow_reg;
    end
  end

  assign irq = irq_reg;
`endif

endmodule

// File: tb/tb_adam_periph_spi_fifo.sv
// Directed and randomized checks of adam_periph_spi_fifo against queue-based
// reference behaviour; IRQ checks built when ADAM_PERIPH_SPI_FIFO_IRQ_EN is defined.
module tb_adam_periph_spi_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int LW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          pause_req = 1'b0, pause_ack, phy_pause_req, phy_pause_ack = 1'b0;
  logic          flush = 1'b0;
  logic [DW-1:0] tx_data = '0, rx_data, phy_tx, phy_rx = '0;
  logic          tx_valid = 1'b0, tx_ready, rx_valid, rx_ready = 1'b0;
  logic          phy_tx_valid, phy_tx_ready = 1'b0, phy_rx_valid = 1'b0, phy_rx_ready;
  logic [LW-1:0] tx_level, rx_level;
  logic          rx_overflow;
`ifdef ADAM_PERIPH_SPI_FIFO_IRQ_EN
  logic [LW-1:0] tx_thresh = '0, rx_thresh = '0;
  logic          irq;
`endif

  adam_periph_spi_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .pause_req(pause_req), .pause_ack(pause_ack),
    .phy_pause_req(phy_pause_req), .phy_pause_ack(phy_pause_ack),
    .flush(flush),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .phy_tx(phy_tx), .phy_tx_valid(phy_tx_valid), .phy_tx_ready(phy_tx_ready),
    .phy_rx(phy_rx), .phy_rx_valid(phy_rx_valid), .phy_rx_ready(phy_rx_ready),
    .tx_level(tx_level), .rx_level(rx_level), .rx_overflow(rx_overflow)
`ifdef ADAM_PERIPH_SPI_FIFO_IRQ_EN
    , .tx_thresh(tx_thresh), .rx_thresh(rx_thresh), .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int tx_q[$], rx_q[$], tx_out[$], rx_out[$];
  bit ovf_m  = 1'b0;
  bit tx_acc = 1'b0;
  int idx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs are driven 2 time units after each rising edge and sampled 1 unit later.
  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic chk_model(input string tag);
    $display("%s: tx_level=%0d rx_level=%0d tx_ready=%0b phy_tx_valid=%0b rx_valid=%0b",
             tag, tx_level, rx_level, tx_ready, phy_tx_valid, rx_valid);
    chk("tx_level", tx_level, tx_q.size());
    chk("rx_level", rx_level, rx_q.size());
    chk("tx_ready", tx_ready, tx_q.size() < DEPTH);
    chk("phy_tx_valid", phy_tx_valid, tx_q.size() > 0);
    chk("phy_tx", phy_tx, (tx_q.size() > 0) ? tx_q[0] : 0);
    chk("rx_valid", rx_valid, rx_q.size() > 0);
    chk("rx_data", rx_data, (rx_q.size() > 0) ? rx_q[0] : 0);
    chk("rx_overflow", rx_overflow, ovf_m);
  endtask

  // One cycle in RUN: check, then advance the reference by the handshakes seen.
  task automatic run_cycle(input string tag);
    bit tpop, tpush, rpop;
    #1;
    chk_model(tag);
    tpop  = (tx_q.size() > 0) && phy_tx_ready;
    tpush = tx_valid && (tx_q.size() < DEPTH);
    rpop  = rx_ready && (rx_q.size() > 0);
    tx_acc = tpush;
    if (tpop) tx_out.push_back(tx_q.pop_front());
    if (tpush) tx_q.push_back(int'(tx_data));
    if (rpop) rx_out.push_back(rx_q.pop_front());
    if (phy_rx_valid) begin
      if (rx_q.size() < DEPTH) rx_q.push_back(int'(phy_rx));
      else ovf_m = 1'b1;
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #1;
    chk("rst.tx_ready", tx_ready, 0);
    chk("rst.phy_tx_valid", phy_tx_valid, 0);
    chk("rst.rx_valid", rx_valid, 0);
    chk("rst.pause_ack", pause_ack, 0);
    chk("rst.phy_pause_req", phy_pause_req, 0);
    chk("rst.levels", {tx_level, rx_level}, 0);
    chk("rst.rx_overflow", rx_overflow, 0);
    chk("rst.phy_tx", phy_tx, 0);
    chk("rst.rx_data", rx_data, 0);
    tick();
    rst = 1'b1;
    #1;
    chk("release.tx_ready_low", tx_ready, 0);
    tick();
    #1;
    chk("release.tx_ready_high", tx_ready, 1);

    // Fill TX with a stalled PHY, then drain in order
    phy_tx_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 14; c++) begin
      tx_valid = 1'b1;
      tx_data  = 32'hAA + idx;
      run_cycle("fill");
      if (tx_acc) idx++;
    end
    chk("fill.accepted", idx, 8);
    chk("fill.tx_ready", tx_ready, 0);
    chk("fill.tx_level", tx_level, 8);
    phy_tx_ready = 1'b1;
    tx_out.delete();
    for (int c = 0; c < 40 && tx_out.size() < 10; c++) begin
      tx_valid = (idx < 10);
      tx_data  = 32'hAA + idx;
      run_cycle("drain");
      if (tx_acc) idx++;
    end
    tx_valid = 1'b0;
    chk("drain.count", tx_out.size(), 10);
    for (int i = 0; i < tx_out.size(); i++) chk("drain.order", tx_out[i], 32'hAA + i);

    // RX overflow with a stalled reader
    rx_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      phy_rx_valid = 1'b1;
      phy_rx       = i;
      run_cycle("rxfill");
    end
    phy_rx_valid = 1'b0;
    #1;
    chk("rxfill.rx_level", rx_level, 8);
    chk("rxfill.rx_overflow", rx_overflow, 1);
    rx_ready = 1'b1;
    rx_out.delete();
    for (int i = 0; i < 8; i++) run_cycle("rxread");
    chk("rxread.count", rx_out.size(), 8);
    for (int i = 0; i < rx_out.size(); i++) chk("rxread.order", rx_out[i], i);

    // Randomized traffic against the reference queues
    for (int c = 0; c < 300; c++) begin
      if (!(tx_valid && !tx_acc)) begin
        tx_valid = 1'($urandom_range(0, 1));
        tx_data  = $urandom;
      end
      phy_tx_ready = (c < 150) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      phy_rx_valid = 1'($urandom_range(0, 1));
      phy_rx       = $urandom;
      rx_ready     = (c < 150) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
      run_cycle("rand");
    end
    tx_valid = 1'b0; phy_rx_valid = 1'b0; phy_tx_ready = 1'b1; rx_ready = 1'b1;
    for (int c = 0; c < 20; c++) run_cycle("flushout");
    ovf_m = 1'b1;
    chk("flushout.rx_overflow_sticky", rx_overflow, 1);

    // Pause with a pending PHY offer
    phy_tx_ready = 1'b0; rx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tx_valid = 1'b1;
      tx_data  = 32'h10 + i;
      run_cycle("pwrite");
    end
    tx_valid  = 1'b0;
    pause_req = 1'b1;
    #1;
    chk("pause.run_valid", phy_tx_valid, 1);
    chk("pause.run_req", phy_pause_req, 0);
    tick();
    for (int c = 0; c < 3; c++) begin
      #1;
      $display("pausing hold %0d: phy_tx_valid=%0b phy_pause_req=%0b", c, phy_tx_valid, phy_pause_req);
      chk("pausing.valid_held", phy_tx_valid, 1);
      chk("pausing.data_held", phy_tx, 32'h10);
      chk("pausing.req_low", phy_pause_req, 0);
      chk("pausing.tx_ready", tx_ready, 0);
      tick();
    end
    phy_tx_ready = 1'b1;
    tick();
    phy_tx_ready = 1'b0;
    phy_rx_valid = 1'b1;
    phy_rx       = 32'h55;
    #1;
    chk("pausing.valid_dropped", phy_tx_valid, 0);
    chk("pausing.req_high", phy_pause_req, 1);
    chk("pausing.tx_level", tx_level, 3);
    chk("pausing.no_ack", pause_ack, 0);
    tick();
    phy_rx        = 32'h66;
    phy_pause_ack = 1'b1;
    tick();
    phy_rx_valid = 1'b0;
    #1;
    chk("paused.pause_ack", pause_ack, 1);
    chk("paused.phy_tx_valid", phy_tx_valid, 0);
    chk("paused.rx_level", rx_level, 2);
    chk("paused.tx_level", tx_level, 3);
    chk("paused.rx_overflow", rx_overflow, 1);

    // Flush inside PAUSED
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    $display("flush paused: tx_level=%0d rx_level=%0d rx_overflow=%0b", tx_level, rx_level, rx_overflow);
    chk("flush.tx_level", tx_level, 0);
    chk("flush.rx_level", rx_level, 0);
    chk("flush.rx_overflow", rx_overflow, 0);
    tx_q.delete(); rx_q.delete(); ovf_m = 1'b0;

    // Resume
    pause_req = 1'b0;
    tick();
    #1;
    chk("resuming.phy_pause_req", phy_pause_req, 0);
    chk("resuming.pause_ack", pause_ack, 0);
    chk("resuming.phy_tx_valid", phy_tx_valid, 0);
    chk("resuming.tx_ready", tx_ready, 0);
    phy_pause_ack = 1'b0;
    tick();
    #1;
    chk("resumed.tx_ready", tx_ready, 1);

    // Flush in RUN is ignored
    for (int i = 0; i < 2; i++) begin
      tx_valid     = 1'b1;
      tx_data      = 32'h20 + i;
      phy_rx_valid = (i == 0);
      phy_rx       = 32'h77;
      run_cycle("runfill");
    end
    tx_valid = 1'b0; phy_rx_valid = 1'b0;
    flush = 1'b1;
    run_cycle("runflush");
    flush = 1'b0;
    run_cycle("runflush_after");
    chk("runflush.tx_level", tx_level, 2);

    // Asynchronous reset with five words stored
    for (int i = 0; i < 3; i++) begin
      tx_valid = 1'b1;
      tx_data  = 32'h30 + i;
      run_cycle("prerst");
    end
    tx_valid = 1'b0;
    #1;
    chk("prerst.tx_level", tx_level, 5);
    rst = 1'b0;
    #1;
    $display("async reset: tx_level=%0d phy_tx_valid=%0b tx_ready=%0b", tx_level, phy_tx_valid, tx_ready);
    chk("arst.tx_level", tx_level, 0);
    chk("arst.rx_level", rx_level, 0);
    chk("arst.phy_tx_valid", phy_tx_valid, 0);
    chk("arst.tx_ready", tx_ready, 0);
    chk("arst.rx_valid", rx_valid, 0);
    chk("arst.phy_tx", phy_tx, 0);
    chk("arst.rx_data", rx_data, 0);
    tick();
    tick();
    rst = 1'b1;
    tx_q.delete(); rx_q.delete(); ovf_m = 1'b0;
    tick();
    #1;
    chk("postrst.tx_level", tx_level, 0);
    chk("postrst.phy_tx_valid", phy_tx_valid, 0);

`ifdef ADAM_PERIPH_SPI_FIFO_IRQ_EN
    // Threshold interrupt: keep TX above its threshold so only RX drives irq
    tx_thresh = '0;
    rx_thresh = 4'd4;
    phy_tx_ready = 1'b0; rx_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tx_valid = 1'b1;
      tx_data  = 32'h40 + i;
      run_cycle("irq_tx");
    end
    tx_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      phy_rx_valid = 1'b1;
      phy_rx       = i;
      run_cycle("irq_rx");
    end
    phy_rx_valid = 1'b0;
    run_cycle("irq_idle");
    chk("irq.below", irq, 0);
    phy_rx_valid = 1'b1;
    phy_rx       = 32'h3;
    run_cycle("irq_rx4");
    phy_rx_valid = 1'b0;
    tick();
    #1;
    chk("irq.at_thresh", irq, 1);
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    tick();
    #1;
    chk("irq.after_read", irq, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
